// File: rtl/sobol_pkg.sv
// Shared FP16 field layout, fixed-point output width, flag codes and sample classes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sobol_pkg;

    localparam int SIGN_W   = 1;
    localparam int EXP_W    = 5;
    localparam int MANT_W   = 10;
    localparam int FP16_W   = SIGN_W + EXP_W + MANT_W;
    localparam int EXP_BIAS = 15;
    localparam int EXP_MAX  = 31;
    localparam int FRAC_W   = 32;

    // A normal value {1,mant} * 2^(e-bias-mant_w) scaled by 2^FRAC_W is a left shift by e+7.
    localparam int NORM_SHIFT_OFS = FRAC_W - MANT_W - EXP_BIAS;
    // Subnormals use the fixed exponent 1-bias, i.e. the normal shift with e = 1.
    localparam int SUB_SHIFT      = NORM_SHIFT_OFS + 1;

    localparam logic [1:0] FLAG_OK    = 2'b00;
    localparam logic [1:0] FLAG_NEG   = 2'b01;
    localparam logic [1:0] FLAG_RANGE = 2'b10;
    localparam logic [1:0] FLAG_NAN   = 2'b11;

    // Magnitude class; the sign is carried separately and applied after NaN detection.
    typedef enum logic [2:0] {
        CLS_ZERO  = 3'd0,
        CLS_SUB   = 3'd1,
        CLS_NORM  = 3'd2,
        CLS_RANGE = 3'd3,
        CLS_NAN   = 3'd4
    } cls_t;

endpackage

// File: rtl/fp16_to_frac32_if.sv
// Sample-in / fraction-out handshake bundle for fp16_to_frac32.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both sides; master drives samples and out_ready.
interface fp16_to_frac32_if;

    logic                          in_valid;
    logic [sobol_pkg::FP16_W-1:0]  in_fp16;
    logic                          in_ready;
    logic                          out_valid;
    logic                          out_ready;
    logic [sobol_pkg::FRAC_W-1:0]  out_frac;
    logic [1:0]                    out_flag;

    modport master (
        output in_valid, in_fp16, out_ready,
        input  in_ready, out_valid, out_frac, out_flag
    );

    modport slave (
        input  in_valid, in_fp16, out_ready,
        output in_ready, out_valid, out_frac, out_flag
    );

endinterface

// File: rtl/fp16_unpack.sv
// Splits an FP16 word into sign/exponent/mantissa and classifies its magnitude.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the caller registers the result.
module fp16_unpack
    import sobol_pkg::*;
(
    input  logic [FP16_W-1:0] fp16_i,
    output logic              sign_o,
    output logic [EXP_W-1:0]  exp_o,
    output logic [MANT_W-1:0] mant_o,
    output cls_t              cls_o
);

    assign sign_o = fp16_i[FP16_W-1];
    assign exp_o  = fp16_i[MANT_W +: EXP_W];
    assign mant_o = fp16_i[MANT_W-1:0];

    // Classify magnitude: NaN first, then anything >= 1.0 (incl. Inf), then zero/subnormal.
    always_comb begin
        cls_o = CLS_NORM;
        if (exp_o == EXP_W'(EXP_MAX)) begin
            cls_o = (mant_o != '0) ? CLS_NAN : CLS_RANGE;
        end else if (exp_o >= EXP_W'(EXP_BIAS)) begin
            cls_o = CLS_RANGE;
        end else if (exp_o == '0) begin
            cls_o = (mant_o == '0) ? CLS_ZERO : CLS_SUB;
        end
    end

endmodule

// File: rtl/fp16_to_frac32.sv
// Converts FP16 samples in [0,1) to unsigned Q0.32 with status flag, plus transfer/error counters.
// Latency: 2 cycles (S1 unpack/classify, S2 shift/saturate), 1 sample/cycle.
// Backpressure: each stage loads when empty or draining; out_frac/out_flag hold while stalled.
module fp16_to_frac32
    import sobol_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int ERR_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    fp16_to_frac32_if.slave    bus,
    output logic [CNT_W-1:0]   sample_cnt,
    output logic [ERR_W-1:0]   err_cnt
);

    logic              u_sign;
    logic [EXP_W-1:0]  u_exp;
    logic [MANT_W-1:0] u_mant;
    cls_t              u_cls;

    logic              rdy_en_q;
    logic              s1_vld_q;
    logic              s1_sign_q;
    logic [EXP_W-1:0]  s1_exp_q;
    logic [MANT_W-1:0] s1_mant_q;
    cls_t              s1_cls_q;

    logic              out_vld_q;
    logic [FRAC_W-1:0] out_frac_q, out_frac_d;
    logic [1:0]        out_flag_q, out_flag_d;
    logic [5:0]        norm_sh;

    logic [CNT_W-1:0]  sample_cnt_q, sample_cnt_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;

    logic              s2_adv;
    logic              in_rdy;
    logic              out_xfer;

    fp16_unpack u_unpack (
        .fp16_i (bus.in_fp16),
        .sign_o (u_sign),
        .exp_o  (u_exp),
        .mant_o (u_mant),
        .cls_o  (u_cls)
    );

    // S2 can take new content when empty or when its output leaves this cycle.
    assign s2_adv   = !out_vld_q || bus.out_ready;
    // rdy_en_q keeps in_ready low during reset and for the edge that releases it.
    assign in_rdy   = rdy_en_q && (!s1_vld_q || s2_adv);
    assign out_xfer = out_vld_q && bus.out_ready;

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_vld_q;
    assign bus.out_frac  = out_frac_q;
    assign bus.out_flag  = out_flag_q;
    assign sample_cnt    = sample_cnt_q;
    assign err_cnt       = err_cnt_q;

    // S1: capture the unpacked fields of an accepted sample, or empty out when S2 takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en_q  <= 1'b0;
            s1_vld_q  <= 1'b0;
            s1_sign_q <= 1'b0;
            s1_exp_q  <= '0;
            s1_mant_q <= '0;
            s1_cls_q  <= CLS_ZERO;
        end else begin
            rdy_en_q <= 1'b1;
            if (in_rdy) begin
                s1_vld_q <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_sign_q <= u_sign;
                    s1_exp_q  <= u_exp;
                    s1_mant_q <= u_mant;
                    s1_cls_q  <= u_cls;
                end
            end
        end
    end

    // S2 data path: NaN beats sign, sign beats range; negative zero converts as plain zero.
    always_comb begin
        out_frac_d = '0;
        out_flag_d = FLAG_OK;
        norm_sh    = {1'b0, s1_exp_q} + 6'(NORM_SHIFT_OFS);
        if (s1_cls_q == CLS_NAN) begin
            out_flag_d = FLAG_NAN;
        end else if (s1_sign_q && (s1_cls_q != CLS_ZERO)) begin
            out_flag_d = FLAG_NEG;
        end else begin
            case (s1_cls_q)
                CLS_NORM:  out_frac_d = FRAC_W'({1'b1, s1_mant_q}) << norm_sh;
                CLS_SUB:   out_frac_d = FRAC_W'(s1_mant_q) << SUB_SHIFT;
                CLS_RANGE: begin
                    out_frac_d = '1;
                    out_flag_d = FLAG_RANGE;
                end
                default:   out_frac_d = '0;
            endcase
        end
    end

    // S2 register: advance when free; data only updates with a real sample so it holds under stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q  <= 1'b0;
            out_frac_q <= '0;
            out_flag_q <= FLAG_OK;
        end else if (s2_adv) begin
            out_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                out_frac_q <= out_frac_d;
                out_flag_q <= out_flag_d;
            end
        end
    end

    // Counter next state: clear dominates; error count sticks at all-ones.
    always_comb begin
        sample_cnt_d = sample_cnt_q;
        err_cnt_d    = err_cnt_q;
        if (clear) begin
            sample_cnt_d = '0;
            err_cnt_d    = '0;
        end else if (out_xfer) begin
            sample_cnt_d = sample_cnt_q + CNT_W'(1);
            if ((out_flag_q != FLAG_OK) && !(&err_cnt_q)) begin
                err_cnt_d = err_cnt_q + ERR_W'(1);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
        end else begin
            sample_cnt_q <= sample_cnt_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_fp16_to_frac32.sv
// Directed bench for fp16_to_frac32: conversion values, latency, stalls, reset, counters.
// Latency: n/a.
// Backpressure: drives out_ready patterns including a multi-cycle stall.
module tb_fp16_to_frac32;

    localparam int CNT_W = 32;
    localparam int ERR_W = 4;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             clear = 1'b0;
    logic [CNT_W-1:0] sample_cnt;
    logic [ERR_W-1:0] err_cnt;

    fp16_to_frac32_if bus();

    fp16_to_frac32 #(.CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .bus        (bus),
        .sample_cnt (sample_cnt),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int errors   = 0;
    int cycle_no = 0;

    logic [31:0] got_frac[$];
    logic [1:0]  got_flag[$];
    int          got_cyc[$];

    logic        last_in_xfer = 1'b0;
    logic        last_in_rdy  = 1'b0;
    logic        stall_q      = 1'b0;
    logic [31:0] stall_frac   = '0;
    logic [1:0]  stall_flag   = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes just before the rising edge, return at the next falling edge.
    task automatic cyc();
        #1;
        if (stall_q) begin
            chk("stall_vld",  {63'd0, bus.out_valid}, 64'd1);
            chk("stall_frac", {32'd0, bus.out_frac}, {32'd0, stall_frac});
            chk("stall_flag", {62'd0, bus.out_flag}, {62'd0, stall_flag});
        end
        last_in_rdy  = bus.in_ready;
        last_in_xfer = bus.in_valid && bus.in_ready;
        if (bus.out_valid && bus.out_ready) begin
            got_frac.push_back(bus.out_frac);
            got_flag.push_back(bus.out_flag);
            got_cyc.push_back(cycle_no);
        end
        stall_q    = bus.out_valid && !bus.out_ready;
        stall_frac = bus.out_frac;
        stall_flag = bus.out_flag;
        @(posedge clk);
        @(negedge clk);
        cycle_no++;
    endtask

    task automatic clear_q();
        got_frac.delete();
        got_flag.delete();
        got_cyc.delete();
    endtask

    logic [15:0] t2_in[3]   = '{16'h3BFF, 16'h0001, 16'h0000};
    logic [31:0] t2_exp[3]  = '{32'hFFE00000, 32'h00000100, 32'h00000000};
    logic [15:0] t3_in[5]   = '{16'h3C00, 16'h7C00, 16'h7E00, 16'hB800, 16'h8000};
    logic [31:0] t3_frac[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0};
    logic [1:0]  t3_flag[5] = '{2'b10, 2'b10, 2'b11, 2'b01, 2'b00};

    initial begin
        int c0;
        int sent;
        int fall_k;
        int n;

        bus.in_valid  = 1'b0;
        bus.in_fp16   = '0;
        bus.out_ready = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready",  {63'd0, bus.in_ready}, 64'd0);
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_out_frac",  {32'd0, bus.out_frac}, 64'd0);
        chk("rst_out_flag",  {62'd0, bus.out_flag}, 64'd0);
        chk("rst_sample_cnt", {32'd0, sample_cnt}, 64'd0);
        chk("rst_err_cnt",   {60'd0, err_cnt}, 64'd0);
        rst_n = 1'b1;
        cyc();
        chk("rel_in_ready", {63'd0, bus.in_ready}, 64'd1);

        // 0x3800 -> 0.5, out_valid two cycles after accept
        bus.out_ready = 1'b1;
        bus.in_fp16   = 16'h3800;
        bus.in_valid  = 1'b1;
        cyc();
        chk("t1_accept", {63'd0, last_in_xfer}, 64'd1);
        bus.in_valid = 1'b0;
        chk("t1_vld_c1", {63'd0, bus.out_valid}, 64'd0);
        cyc();
        chk("t1_vld_c2", {63'd0, bus.out_valid}, 64'd1);
        chk("t1_frac",   {32'd0, bus.out_frac}, 64'h80000000);
        chk("t1_flag",   {62'd0, bus.out_flag}, 64'd0);
        cyc();
        chk("t1_sample_cnt", {32'd0, sample_cnt}, 64'd1);

        // Back-to-back: max normal below 1, smallest subnormal, zero
        clear_q();
        c0 = cycle_no;
        for (int i = 0; i < 3; i++) begin
            bus.in_fp16  = t2_in[i];
            bus.in_valid = 1'b1;
            cyc();
        end
        bus.in_valid = 1'b0;
        repeat (4) cyc();
        chk("t2_count", 64'(got_frac.size()), 64'd3);
        for (int i = 0; i < got_frac.size() && i < 3; i++) begin
            chk("t2_frac", {32'd0, got_frac[i]}, {32'd0, t2_exp[i]});
            chk("t2_flag", {62'd0, got_flag[i]}, 64'd0);
            chk("t2_cycle", 64'(got_cyc[i]), 64'(c0 + 2 + i));
        end

        // Flag classes and counters
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        chk("t3_clr_sample", {32'd0, sample_cnt}, 64'd0);
        chk("t3_clr_err",    {60'd0, err_cnt}, 64'd0);
        clear_q();
        for (int i = 0; i < 5; i++) begin
            bus.in_fp16  = t3_in[i];
            bus.in_valid = 1'b1;
            cyc();
        end
        bus.in_valid = 1'b0;
        repeat (4) cyc();
        chk("t3_count", 64'(got_frac.size()), 64'd5);
        for (int i = 0; i < got_frac.size() && i < 5; i++) begin
            chk("t3_frac", {32'd0, got_frac[i]}, {32'd0, t3_frac[i]});
            chk("t3_flag", {62'd0, got_flag[i]}, {62'd0, t3_flag[i]});
        end
        chk("t3_err_cnt",    {60'd0, err_cnt}, 64'd4);
        chk("t3_sample_cnt", {32'd0, sample_cnt}, 64'd5);

        // Stream of ten 0.25 samples with a 5-cycle downstream stall
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        clear_q();
        sent   = 0;
        fall_k = -1;
        bus.in_fp16 = 16'h3400;
        for (int k = 0; k < 40; k++) begin
            bus.out_ready = !(k >= 4 && k < 9);
            bus.in_valid  = (sent < 10);
            cyc();
            if (last_in_xfer) sent++;
            if (fall_k < 0 && k >= 4 && !last_in_rdy) fall_k = k;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk("t4_sent",  64'(sent), 64'd10);
        chk("t4_count", 64'(got_frac.size()), 64'd10);
        chk("t4_rdy_fall", {63'd0, (fall_k >= 4 && fall_k <= 6)}, 64'd1);
        for (int i = 0; i < got_frac.size() && i < 10; i++) begin
            chk("t4_frac", {32'd0, got_frac[i]}, 64'h40000000);
            chk("t4_flag", {62'd0, got_flag[i]}, 64'd0);
        end
        chk("t4_sample_cnt", {32'd0, sample_cnt}, 64'd10);

        // Reset with two samples in flight
        bus.in_fp16  = 16'h3800;
        bus.in_valid = 1'b1;
        cyc();
        bus.in_fp16  = 16'h3400;
        cyc();
        bus.in_valid = 1'b0;
        chk("t5_inflight", {63'd0, bus.out_valid}, 64'd1);
        clear_q();
        bus.out_ready = 1'b0;
        rst_n   = 1'b0;
        stall_q = 1'b0;
        #1;
        chk("t5_rst_vld", {63'd0, bus.out_valid}, 64'd0);
        chk("t5_rst_rdy", {63'd0, bus.in_ready}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("t5_rst_sample", {32'd0, sample_cnt}, 64'd0);
        chk("t5_rst_err",    {60'd0, err_cnt}, 64'd0);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        cyc();
        chk("t5_rel_rdy", {63'd0, bus.in_ready}, 64'd1);
        bus.in_fp16  = 16'h3800;
        bus.in_valid = 1'b1;
        cyc();
        bus.in_valid = 1'b0;
        chk("t5_vld_c1", {63'd0, bus.out_valid}, 64'd0);
        cyc();
        chk("t5_vld_c2", {63'd0, bus.out_valid}, 64'd1);
        chk("t5_frac",   {32'd0, bus.out_frac}, 64'h80000000);
        repeat (3) cyc();
        chk("t5_count", 64'(got_frac.size()), 64'd1);

        // Error counter saturation, then clear during a flagged transfer
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        clear_q();
        bus.in_fp16 = 16'h3C00;
        for (int i = 0; i < 15; i++) begin
            bus.in_valid = 1'b1;
            cyc();
        end
        bus.in_valid = 1'b0;
        repeat (3) cyc();
        chk("t6_err_full",  {60'd0, err_cnt}, 64'hF);
        chk("t6_sample_15", {32'd0, sample_cnt}, 64'd15);
        bus.in_fp16 = 16'h7C00;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            cyc();
        end
        bus.in_valid = 1'b0;
        repeat (3) cyc();
        chk("t6_err_sat",   {60'd0, err_cnt}, 64'hF);
        chk("t6_sample_17", {32'd0, sample_cnt}, 64'd17);
        bus.in_fp16  = 16'h3C00;
        bus.in_valid = 1'b1;
        cyc();
        bus.in_valid = 1'b0;
        cyc();
        chk("t6_pre_vld", {63'd0, bus.out_valid}, 64'd1);
        n = got_frac.size();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        chk("t6_xfer_done", 64'(got_frac.size()), 64'(n + 1));
        chk("t6_clr_err",    {60'd0, err_cnt}, 64'd0);
        chk("t6_clr_sample", {32'd0, sample_cnt}, 64'd0);
        bus.in_fp16  = 16'hB800;
        bus.in_valid = 1'b1;
        cyc();
        bus.in_valid = 1'b0;
        repeat (3) cyc();
        chk("t6_err_resume",    {60'd0, err_cnt}, 64'd1);
        chk("t6_sample_resume", {32'd0, sample_cnt}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp16_to_frac32.md
FP16_TO_FRAC32 -- requirements
Module: fp16_to_frac32

Interface
REQ-001 Parameter CNT_W, default 32, width of accepted-sample counter.
REQ-002 Parameter ERR_W, default 16, width of saturating error counter.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  in_fp16 carries a sample.
REQ-006 in_fp16  input  16  IEEE binary16 sample, nominal range [0,1).
REQ-007 in_ready  output  1  block accepts the sample this cycle.
REQ-008 out_valid  output  1  out_frac/out_flag valid.
REQ-009 out_ready  input  1  downstream accepts the output this cycle.
REQ-010 out_frac  output  32  unsigned Q0.32 fraction, value * 2^32.
REQ-011 out_flag  output  2  00 ok, 01 negative, 10 range (>=1 or Inf), 11 NaN.
REQ-012 clear  input  1  synchronous clear of both counters.
REQ-013 sample_cnt  output  CNT_W  count of completed output transfers.
REQ-014 err_cnt  output  ERR_W  count of completed transfers with out_flag != 00.

Function
REQ-015 Transfer on in_valid && in_ready (input) and out_valid && out_ready (output).
REQ-016 Two registered stages: S1 unpack/classify, S2 shift/saturate; out_valid/out_frac/out_flag are S2 registers.
REQ-017 Latency exactly 2 cycles from input transfer to out_valid with no stall; throughput 1 sample/cycle.
REQ-018 Each stage loads when empty or when its content moves on in the same cycle; in_ready = !S1_valid || S1 advancing; in_ready does not depend combinationally on in_valid.
REQ-019 No sample is dropped, duplicated or reordered under any out_ready pattern; out_frac/out_flag stay stable while out_valid && !out_ready.
REQ-020 Normal, e in 1..14, sign 0: out_frac = {1,mant} << (e+7); flag 00; exact.
REQ-021 Subnormal/zero, e = 0, sign 0: out_frac = mant << 8; flag 00.
REQ-022 e = 15..30, or e = 31 with mant = 0, sign 0: out_frac = 0xFFFFFFFF; flag 10.
REQ-023 e = 31, mant != 0 (either sign): out_frac = 0; flag 11; NaN takes priority over sign.
REQ-024 Sign 1 with nonzero magnitude, non-NaN: out_frac = 0; flag 01; 0x8000 gives 0, flag 00.
REQ-025 sample_cnt increments by 1 per output transfer and wraps modulo 2^CNT_W.
REQ-026 err_cnt increments per output transfer with flag != 00 and saturates at all-ones.
REQ-027 clear zeroes both counters and wins over a same-cycle increment; the pipeline is unaffected.

Reset
REQ-028 While rst_n low: in_ready 0, out_valid 0, out_frac 0, out_flag 00, sample_cnt 0, err_cnt 0, all stage valids 0.
REQ-029 Reset asserted mid-stream discards in-flight samples without emitting them; in_ready rises the first cycle after deassertion.

Structure
REQ-030 Shared package sobol_pkg holds FP16 field widths (1/5/10), EXP_BIAS = 15, FRAC_W = 32, and the out_flag encoding constants.
REQ-031 One combinational sub-module fp16_unpack (sign, exponent, mantissa, class) feeds S1; shifting and saturation stay in the top.

Verification
REQ-032 0x3800 with out_ready held 1 -> out_frac 0x80000000, flag 00, out_valid exactly 2 cycles after accept.
REQ-033 0x3BFF, 0x0001, 0x0000 back-to-back -> 0xFFE00000, 0x00000100, 0x00000000, all flag 00, consecutive cycles.
REQ-034 0x3C00, 0x7C00, 0x7E00, 0xB800, 0x8000 -> (0xFFFFFFFF,10), (0xFFFFFFFF,10), (0,11), (0,01), (0,00); err_cnt = 4, sample_cnt = 5.
REQ-035 Stream 0x3400 x10 with out_ready low for 5 cycles mid-stream -> in_ready falls within 2 cycles, ten 0x40000000 outputs delivered in order, none lost, sample_cnt = 10.
REQ-036 rst_n pulsed low with 2 samples in flight -> no output emitted, counters 0, next accepted 0x3800 yields 0x80000000 after 2 cycles.
REQ-037 Force err_cnt to all-ones with range inputs, then apply clear while a flagged sample transfers -> err_cnt saturates at all-ones, then reads 0 after the clear.
